// File: rtl/serial_paralelo_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_paralelo_rx_pkg
//  Description : Shared constants and state encoding for the serial-to-
//                parallel receiver (idle byte is shared with the transmitter).
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_paralelo_rx_pkg;

    // Idle / alignment byte sent by the transmitter when it has no data
    localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hBC;

    // Receiver alignment state machine
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        COUNT  = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

endpackage : serial_paralelo_rx_pkg
`default_nettype wire

// File: rtl/serial_paralelo_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_paralelo_rx_if
//  Description : Serial input and byte-wide output bundle of the receiver.
//                master = link/consumer side, slave = receiver side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_paralelo_rx_if;

    logic       in_serial;
    logic [7:0] out_parallel;
    logic       out_valid;
    logic       byte_strobe;
    logic       active;

    modport master (
        output in_serial,
        input  out_parallel,
        input  out_valid,
        input  byte_strobe,
        input  active
    );

    modport slave (
        input  in_serial,
        output out_parallel,
        output out_valid,
        output byte_strobe,
        output active
    );

endinterface : serial_paralelo_rx_if
`default_nettype wire

// File: rtl/serial_paralelo_rx_shift8.sv
`default_nettype none
// ============================================================================
//  Module      : serial_shift8
//  Description : 8-bit MSB-first shift register. sr_next is the value the
//                register takes at the coming edge, so a byte is visible in
//                the same cycle its last bit is on the input.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_shift8 (
    input  wire logic       clk_32f,
    input  wire logic       reset,
    input  wire logic       in_serial,
    output logic [7:0]      sr_next
);

    logic [7:0] sr_q;
    logic [7:0] sr_d;

    // Shift the new bit in at the LSB end
    always_comb begin
        sr_d = {sr_q[6:0], in_serial};
    end

    assign sr_next = sr_d;

    // Shift register storage, cleared by reset
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule : serial_shift8
`default_nettype wire

// File: rtl/serial_paralelo_rx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_paralelo_rx
//  Description : Deserialises an MSB-first bit stream into bytes. Hunts for
//                the idle byte at any bit offset, confirms byte alignment over
//                LOCK_COUNT consecutive idle bytes, then locks and reports each
//                byte with a valid flag that is low for idle bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_paralelo_rx
    import serial_paralelo_rx_pkg::*;
#(
    parameter logic [7:0]  IDLE_BYTE  = IDLE_BYTE_DEFAULT,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  wire logic           clk_32f,
    input  wire logic           reset,
    serial_paralelo_rx_if.slave bus
);

    localparam logic [3:0] LOCK_COUNT_C = LOCK_COUNT[3:0];

    logic [7:0] sr_next;

    rx_state_t  state_q,        state_d;
    logic [2:0] bit_cnt_q,      bit_cnt_d;
    logic [3:0] bc_cnt_q,       bc_cnt_d;
    logic [7:0] out_parallel_q, out_parallel_d;
    logic       out_valid_q,    out_valid_d;
    logic       byte_strobe_q,  byte_strobe_d;

    logic       idle_match;
    logic       at_boundary;

    serial_shift8 u_shift (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .in_serial (bus.in_serial),
        .sr_next   (sr_next)
    );

    assign idle_match  = (sr_next == IDLE_BYTE);
    assign at_boundary = (bit_cnt_q == 3'd7);

    // Next-state, counter and output-register logic
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        bc_cnt_d       = bc_cnt_q;
        out_parallel_d = out_parallel_q;
        out_valid_d    = out_valid_q;
        byte_strobe_d  = 1'b0;

        unique case (state_q)
            HUNT: begin
                // No alignment assumed: every cycle is a candidate boundary
                if (idle_match) begin
                    bit_cnt_d = 3'd0;
                    if (LOCK_COUNT == 1) begin
                        state_d = LOCKED;
                    end else begin
                        state_d  = COUNT;
                        bc_cnt_d = 4'd1;
                    end
                end
            end
            COUNT: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (at_boundary) begin
                    if (idle_match) begin
                        if ((bc_cnt_q + 4'd1) == LOCK_COUNT_C) begin
                            state_d  = LOCKED;
                            bc_cnt_d = 4'd0;
                        end else begin
                            bc_cnt_d = bc_cnt_q + 4'd1;
                        end
                    end else begin
                        // Alignment broken: resume hunting on the next bit
                        state_d  = HUNT;
                        bc_cnt_d = 4'd0;
                    end
                end
            end
            LOCKED: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (at_boundary) begin
                    out_parallel_d = sr_next;
                    out_valid_d    = !idle_match;
                    byte_strobe_d  = 1'b1;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // State, counters and output registers; reset discards all progress
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q        <= HUNT;
            bit_cnt_q      <= 3'd0;
            bc_cnt_q       <= 4'd0;
            out_parallel_q <= 8'd0;
            out_valid_q    <= 1'b0;
            byte_strobe_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            bc_cnt_q       <= bc_cnt_d;
            out_parallel_q <= out_parallel_d;
            out_valid_q    <= out_valid_d;
            byte_strobe_q  <= byte_strobe_d;
        end
    end

    assign bus.out_parallel = out_parallel_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.byte_strobe  = byte_strobe_q;
    assign bus.active       = (state_q == LOCKED);

endmodule : serial_paralelo_rx
`default_nettype wire
